// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared widths, write-back selects and status bit positions for the SISC datapath
package sisc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_MEM = 1'b1;

    localparam int STAT_C = 3;
    localparam int STAT_V = 2;
    localparam int STAT_N = 1;
    localparam int STAT_Z = 0;

endpackage

// File: rtl/sisc_rf_bank.sv
// rtl/sisc_rf_bank.sv - 2R/1W register array with R0 tied to zero
module sisc_rf_bank
    import sisc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int REG_CNT = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [REG_CNT];

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            for (int i = 0; i < REG_CNT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            r_mem[waddr] <= wdata;
        end
    end

    // R0 is forced on the read side too, so it is zero even before the first reset
    assign rdata_a = (raddr_a == '0) ? '0 : r_mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : r_mem[raddr_b];

endmodule

// File: rtl/sisc_rf_wb.sv
// rtl/sisc_rf_wb.sv - register file write-back datapath and status register
// Build option: SISC_RF_BYPASS_EN forwards the write-back value to a read port reading the register being written.
module sisc_rf_wb
    import sisc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              rf_we,
    input  logic              wb_sel,
    input  logic              stat_en,
    input  logic [ADDR_W-1:0] read_rega,
    input  logic [ADDR_W-1:0] read_regb,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [3:0]        alu_stat,
    output logic [DATA_W-1:0] rsa,
    output logic [DATA_W-1:0] rsb,
    output logic [3:0]        stat
);

    logic [DATA_W-1:0] w_wb_data;
    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;
    logic [3:0]        r_stat;

    assign w_wb_data = (wb_sel == WB_MEM) ? mem_data : alu_result;

    sisc_rf_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .rst_f   (rst_f),
        .we      (rf_we),
        .waddr   (write_reg),
        .wdata   (w_wb_data),
        .raddr_a (read_rega),
        .raddr_b (read_regb),
        .rdata_a (w_rdata_a),
        .rdata_b (w_rdata_b)
    );

`ifdef SISC_RF_BYPASS_EN
    logic w_fwd_a;
    logic w_fwd_b;

    assign w_fwd_a = rf_we && (write_reg != '0) && (write_reg == read_rega);
    assign w_fwd_b = rf_we && (write_reg != '0) && (write_reg == read_regb);
    assign rsa     = w_fwd_a ? w_wb_data : w_rdata_a;
    assign rsb     = w_fwd_b ? w_wb_data : w_rdata_b;
`else
    assign rsa = w_rdata_a;
    assign rsb = w_rdata_b;
`endif

    // stat is never forwarded; ctrl sees new flags only after the edge
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            r_stat <= 4'b0000;
        end else if (stat_en) begin
            r_stat <= alu_stat;
        end
    end

    assign stat = r_stat;

endmodule

// File: tb/tb_sisc_rf_wb.sv
// tb/tb_sisc_rf_wb.sv - directed self-checking bench for sisc_rf_wb
module tb_sisc_rf_wb;
    import sisc_pkg::*;

    logic        clk;
    logic        rst_f;
    logic        rf_we;
    logic        wb_sel;
    logic        stat_en;
    logic [3:0]  read_rega;
    logic [3:0]  read_regb;
    logic [3:0]  write_reg;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [3:0]  alu_stat;
    logic [31:0] rsa;
    logic [31:0] rsb;
    logic [3:0]  stat;

    int n_vec;
    int n_err;
    logic [31:0] model [16];

    sisc_rf_wb dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .stat_en    (stat_en),
        .read_rega  (read_rega),
        .read_regb  (read_regb),
        .write_reg  (write_reg),
        .alu_result (alu_result),
        .mem_data   (mem_data),
        .alu_stat   (alu_stat),
        .rsa        (rsa),
        .rsb        (rsb),
        .stat       (stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        n_vec++;
        if ($isunknown(rf_we) || $isunknown(stat_en)) begin
            n_err++;
            $display("FAIL protocol_x rf_we=%b stat_en=%b required known values", rf_we, stat_en);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf_we = 1'b0; stat_en = 1'b0; wb_sel = WB_ALU;
        write_reg = 4'd0; alu_result = '0; mem_data = '0; alu_stat = 4'b0000;
    endtask

    task automatic write_alu(input logic [3:0] idx, input logic [31:0] val);
        rf_we = 1'b1; wb_sel = WB_ALU; write_reg = idx;
        alu_result = val; mem_data = ~val;
        tick();
        idle();
        if (idx != 4'd0) model[idx] = val;
    endtask

    task automatic check_all(input string name);
        for (int i = 0; i < 16; i++) begin
            read_rega = 4'(i);
            read_regb = 4'(15 - i);
            #1;
            n_vec++;
            if (rsa !== model[i]) begin
                n_err++;
                $display("FAIL %s rsa R%0d got %h required %h", name, i, rsa, model[i]);
            end
            n_vec++;
            if (rsb !== model[15 - i]) begin
                n_err++;
                $display("FAIL %s rsb R%0d got %h required %h", name, 15 - i, rsb, model[15 - i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_f = 1'b1;
        write_alu(4'd2, 32'hDEAD_BEEF);
        write_alu(4'd11, 32'h0BAD_F00D);
        write_alu(4'd15, 32'hFFFF_0001);
        stat_en = 1'b1; alu_stat = 4'b1111;
        tick();
        idle();
        rst_f = 1'b0;
        tick();
        tick();
        rst_f = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = '0;
        check_all("reset");
        n_vec++;
        if (stat !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_stat got %b required 0000", stat);
        end
    endtask

    task automatic test_write_alu();
        rf_we = 1'b1; wb_sel = WB_ALU; write_reg = 4'd3;
        alu_result = 32'h1234_5678; mem_data = 32'h8765_4321;
        tick();
        idle();
        model[3] = 32'h1234_5678;
        read_rega = 4'd3; read_regb = 4'd3;
        #1;
        n_vec++;
        if (rsa !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL write_alu rsa got %h required 12345678", rsa);
        end
        n_vec++;
        if (rsb !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL write_alu_dual rsb got %h required 12345678", rsb);
        end
    endtask

    task automatic test_write_mem();
        rf_we = 1'b1; wb_sel = WB_MEM; write_reg = 4'd4;
        alu_result = 32'h0000_1111; mem_data = 32'hCAFE_0004;
        tick();
        idle();
        model[4] = 32'hCAFE_0004;
        read_regb = 4'd4;
        #1;
        n_vec++;
        if (rsb !== 32'hCAFE_0004) begin
            n_err++;
            $display("FAIL write_mem rsb got %h required cafe0004", rsb);
        end
    endtask

    task automatic test_r0();
        rf_we = 1'b1; wb_sel = WB_MEM; write_reg = 4'd0;
        mem_data = 32'hFFFF_FFFF; alu_result = 32'hFFFF_FFFF;
        read_rega = 4'd0; read_regb = 4'd0;
        #1;
        n_vec++;
        if (rsa !== 32'h0) begin
            n_err++;
            $display("FAIL r0_same_cycle rsa got %h required 00000000", rsa);
        end
        tick();
        idle();
        n_vec++;
        if (rsa !== 32'h0 || rsb !== 32'h0) begin
            n_err++;
            $display("FAIL r0_after rsa=%h rsb=%h required 00000000", rsa, rsb);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_now;
        write_alu(4'd5, 32'h1111_1111);
        write_alu(4'd6, 32'h6666_6666);
        rf_we = 1'b1; wb_sel = WB_ALU; write_reg = 4'd5;
        alu_result = 32'hA5A5_A5A5; mem_data = 32'h5A5A_5A5A;
        read_rega = 4'd5; read_regb = 4'd6;
        #1;
`ifdef SISC_RF_BYPASS_EN
        exp_now = 32'hA5A5_A5A5;
`else
        exp_now = 32'h1111_1111;
`endif
        n_vec++;
        if (rsa !== exp_now) begin
            n_err++;
            $display("FAIL rdw_same_cycle rsa got %h required %h", rsa, exp_now);
        end
        n_vec++;
        if (rsb !== 32'h6666_6666) begin
            n_err++;
            $display("FAIL rdw_other_port rsb got %h required 66666666", rsb);
        end
        tick();
        idle();
        model[5] = 32'hA5A5_A5A5;
        n_vec++;
        if (rsa !== 32'hA5A5_A5A5) begin
            n_err++;
            $display("FAIL rdw_next_cycle rsa got %h required a5a5a5a5", rsa);
        end
    endtask

    task automatic test_stat();
        rf_we = 1'b1; wb_sel = WB_ALU; write_reg = 4'd7; alu_result = 32'h0000_0777;
        stat_en = 1'b1; alu_stat = 4'b1001;
        #1;
        n_vec++;
        if (stat !== 4'b0000) begin
            n_err++;
            $display("FAIL stat_no_bypass got %b required 0000", stat);
        end
        tick();
        idle();
        model[7] = 32'h0000_0777;
        read_rega = 4'd7;
        #1;
        n_vec++;
        if (stat !== 4'b1001 || stat[STAT_C] !== 1'b1 || stat[STAT_Z] !== 1'b1) begin
            n_err++;
            $display("FAIL stat_load got %b required 1001", stat);
        end
        n_vec++;
        if (rsa !== 32'h0000_0777) begin
            n_err++;
            $display("FAIL stat_with_write rsa got %h required 00000777", rsa);
        end
        stat_en = 1'b0; alu_stat = 4'b0110;
        tick();
        tick();
        n_vec++;
        if (stat !== 4'b1001) begin
            n_err++;
            $display("FAIL stat_hold got %b required 1001", stat);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i < 16; i++) begin
            rf_we = 1'b1; write_reg = 4'(i);
            wb_sel = (i % 2 == 1) ? WB_MEM : WB_ALU;
            mem_data   = 32'hC0DE_0000 | 32'(i);
            alu_result = 32'hBEEF_0000 | 32'(i);
            model[i] = (i % 2 == 1) ? (32'hC0DE_0000 | 32'(i)) : (32'hBEEF_0000 | 32'(i));
            tick();
        end
        idle();
        check_all("back_to_back");
    endtask

    task automatic test_reset_priority();
        rst_f = 1'b0;
        rf_we = 1'b1; wb_sel = WB_ALU; write_reg = 4'd9; alu_result = 32'h9999_9999;
        stat_en = 1'b1; alu_stat = 4'b1111;
        tick();
        idle();
        rst_f = 1'b1;
        read_rega = 4'd9; read_regb = 4'd7;
        #1;
        n_vec++;
        if (rsa !== 32'h0) begin
            n_err++;
            $display("FAIL rst_prio_r9 got %h required 00000000", rsa);
        end
        n_vec++;
        if (rsb !== 32'h0) begin
            n_err++;
            $display("FAIL rst_prio_r7 got %h required 00000000", rsb);
        end
        n_vec++;
        if (stat !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_prio_stat got %b required 0000", stat);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        rst_f = 1'b0;
        read_rega = 4'd0;
        read_regb = 4'd0;
        idle();
        tick();
        tick();
        test_reset();
        test_write_alu();
        test_write_mem();
        test_r0();
        test_bypass();
        test_stat();
        test_back_to_back();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
